// File: rtl/bram_decode_write_if.sv
// Read-beat and BRAM write bus between the NTT butterfly datapath and the write-back decoder.
// The datapath side (master) issues beats and BU results; the decoder side (slave) drives bank writes.
interface bram_decode_write_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADW        = 5
);
  logic                    valid_i;
  logic                    last_i;
  logic [63:0]             addr_core_i;
  logic [7:0]              olen_i;
  logic [8*DATA_WIDTH-1:0] data_a_i;
  logic [8*DATA_WIDTH-1:0] data_b_i;

  logic [7:0]              we_a_o;
  logic [8*ADW-1:0]        addr_a_o;
  logic [8*DATA_WIDTH-1:0] din_a_o;
  logic [7:0]              we_b_o;
  logic [8*ADW-1:0]        addr_b_o;
  logic [8*DATA_WIDTH-1:0] din_b_o;

  modport master (
    output valid_i, last_i, addr_core_i, olen_i, data_a_i, data_b_i,
    input  we_a_o, addr_a_o, din_a_o, we_b_o, addr_b_o, din_b_o
  );

  modport slave (
    input  valid_i, last_i, addr_core_i, olen_i, data_a_i, data_b_i,
    output we_a_o, addr_a_o, din_a_o, we_b_o, addr_b_o, din_b_o
  );
endinterface

// File: rtl/bram_decode_write.sv
// Write-back address decoder: delays read-beat addresses by the butterfly latency, then
// routes the 16 BU results onto the port-A/port-B write interfaces of the 8 coefficient banks.
module bram_decode_write #(
  parameter int DATA_WIDTH = 12,
  parameter int ADW        = 5,
  parameter int BU_LAT     = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  bram_decode_write_if.slave bus,
  output logic               busy_o,
  output logic               done_o,
  output logic               conflict_o
);

  localparam int NL = 8;
  localparam int BW = 8 - ADW;

  typedef struct packed {
    logic          valid;
    logic          last;
    logic [NL*8-1:0] core;
    logic [7:0]    olen;
  } beat_t;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  beat_t                    dl_q [BU_LAT];
  beat_t                    tail_q;
  logic [NL*DATA_WIDTH-1:0] tail_da_q;
  logic [NL*DATA_WIDTH-1:0] tail_db_q;

  logic [7:0]               lane_a [NL];
  logic [7:0]               lane_b [NL];

  logic [NL-1:0]            we_a_d;
  logic [NL-1:0]            we_b_d;
  logic [NL*ADW-1:0]        addr_a_d;
  logic [NL*ADW-1:0]        addr_b_d;
  logic [NL*DATA_WIDTH-1:0] din_a_d;
  logic [NL*DATA_WIDTH-1:0] din_b_d;
  logic                     conf_d;

  logic [NL-1:0]            we_a_q;
  logic [NL-1:0]            we_b_q;
  logic [NL*ADW-1:0]        addr_a_q;
  logic [NL*ADW-1:0]        addr_b_q;
  logic [NL*DATA_WIDTH-1:0] din_a_q;
  logic [NL*DATA_WIDTH-1:0] din_b_q;
  logic                     done_q;
  logic                     conflict_q;

  state_t                   state_q;
  state_t                   state_d;

  // The tail register sits one stage past the delay line so BU data arriving
  // BU_LAT cycles after the beat is captured alongside its own addresses.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < BU_LAT; i++) begin
        dl_q[i] <= '0;
      end
      tail_q    <= '0;
      tail_da_q <= '0;
      tail_db_q <= '0;
    end else begin
      dl_q[0] <= '{valid: bus.valid_i,
                   last:  bus.valid_i & bus.last_i,
                   core:  bus.addr_core_i,
                   olen:  bus.olen_i};
      for (int unsigned i = 1; i < BU_LAT; i++) begin
        dl_q[i] <= dl_q[i-1];
      end
      tail_q    <= dl_q[BU_LAT-1];
      tail_da_q <= bus.data_a_i;
      tail_db_q <= bus.data_b_i;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NL; k++) begin
      lane_a[k] = tail_q.core[8*k +: 8];
      lane_b[k] = lane_a[k] + tail_q.olen;
    end
  end

  // Lanes are scanned in ascending order per bank, so the first hit claims the
  // port and any later hit on an already-claimed port only raises the conflict.
  always_comb begin
    we_a_d   = '0;
    we_b_d   = '0;
    addr_a_d = '0;
    addr_b_d = '0;
    din_a_d  = '0;
    din_b_d  = '0;
    conf_d   = 1'b0;
    for (int unsigned b = 0; b < NL; b++) begin
      for (int unsigned k = 0; k < NL; k++) begin
        if (tail_q.valid && (lane_a[k][7:ADW] == BW'(b))) begin
          if (we_a_d[b]) begin
            conf_d = 1'b1;
          end else begin
            we_a_d[b]                          = 1'b1;
            addr_a_d[b*ADW +: ADW]             = lane_a[k][ADW-1:0];
            din_a_d[b*DATA_WIDTH +: DATA_WIDTH] = tail_da_q[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        if (tail_q.valid && (lane_b[k][7:ADW] == BW'(b))) begin
          if (we_b_d[b]) begin
            conf_d = 1'b1;
          end else begin
            we_b_d[b]                          = 1'b1;
            addr_b_d[b*ADW +: ADW]             = lane_b[k][ADW-1:0];
            din_b_d[b*DATA_WIDTH +: DATA_WIDTH] = tail_db_q[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      we_a_q     <= '0;
      we_b_q     <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      din_a_q    <= '0;
      din_b_q    <= '0;
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      we_a_q     <= we_a_d;
      we_b_q     <= we_b_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      din_a_q    <= din_a_d;
      din_b_q    <= din_b_d;
      done_q     <= tail_q.valid & tail_q.last;
      // A start in the same cycle as a conflicting write leaves the flag set.
      conflict_q <= (conflict_q & ~start_i) | conf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i || bus.valid_i) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (done_q && !(start_i || bus.valid_i)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.we_a_o   = we_a_q;
  assign bus.we_b_o   = we_b_q;
  assign bus.addr_a_o = addr_a_q;
  assign bus.addr_b_o = addr_b_q;
  assign bus.din_a_o  = din_a_q;
  assign bus.din_b_o  = din_b_q;
  assign done_o       = done_q;
  assign conflict_o   = conflict_q;
  assign busy_o       = (state_q == ST_BUSY);

endmodule

// File: tb/tb_bram_decode_write.sv
// Bench for bram_decode_write: directed and randomized beats checked every cycle against
// a history-based model of the bank routing, busy/done and sticky conflict rules.
module tb_bram_decode_write;
  localparam int DW  = 12;
  localparam int ADW = 5;
  localparam int L   = 4;
  localparam int HW  = 1024;
  localparam int OW  = 2*(8 + 8*ADW + 8*DW) + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, conflict;
  int   checks = 0;
  int   errors = 0;

  bram_decode_write_if #(.DATA_WIDTH(DW), .ADW(ADW)) bus ();

  bram_decode_write #(.DATA_WIDTH(DW), .ADW(ADW), .BU_LAT(L)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .start_i    (start),
    .bus        (bus),
    .busy_o     (busy),
    .done_o     (done),
    .conflict_o (conflict)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [63:0] core;
    logic [7:0]  olen;
  } beat_t;

  beat_t           hist_beat [HW];
  logic [8*DW-1:0] hist_da   [HW];
  logic [8*DW-1:0] hist_db   [HW];
  int              edge_n   = 0;
  int              last_rst = -1000;

  logic [7:0]       m_we_a = '0, m_we_b = '0;
  logic [8*ADW-1:0] m_addr_a = '0, m_addr_b = '0;
  logic [8*DW-1:0]  m_din_a = '0, m_din_b = '0;
  logic             m_busy = 1'b0, m_done = 1'b0, m_conf = 1'b0;

  logic [OW-1:0] obs, exp_v;
  assign obs   = {bus.we_a_o, bus.addr_a_o, bus.din_a_o, bus.we_b_o, bus.addr_b_o, bus.din_b_o,
                  busy, done, conflict};
  assign exp_v = {m_we_a, m_addr_a, m_din_a, m_we_b, m_addr_b, m_din_b, m_busy, m_done, m_conf};

  task automatic rand_data();
    bus.data_a_i = {$urandom(), $urandom(), $urandom()};
    bus.data_b_i = {$urandom(), $urandom(), $urandom()};
  endtask

  task automatic set_idle();
    bus.valid_i     = 1'b0;
    bus.last_i      = 1'b0;
    bus.addr_core_i = {$urandom(), $urandom()};
    bus.olen_i      = 8'($urandom());
  endtask

  // Advance one clock edge and update the model with what that edge must produce.
  task automatic tick();
    beat_t           src;
    logic [8*DW-1:0] sda, sdb;
    logic [7:0]      a8, b8;
    int              ba, bb;
    int              cnt_a [8];
    int              cnt_b [8];
    logic            conf_now, nbusy;
    @(posedge clk);
    edge_n++;
    hist_beat[edge_n % HW] = '{valid: bus.valid_i, last: bus.last_i,
                               core: bus.addr_core_i, olen: bus.olen_i};
    hist_da[edge_n % HW] = bus.data_a_i;
    hist_db[edge_n % HW] = bus.data_b_i;
    if (!rst_n) begin
      m_we_a = '0; m_we_b = '0; m_addr_a = '0; m_addr_b = '0; m_din_a = '0; m_din_b = '0;
      m_busy = 1'b0; m_done = 1'b0; m_conf = 1'b0;
      last_rst = edge_n;
    end else begin
      src = '0;
      if (edge_n - L - 1 > last_rst) src = hist_beat[(edge_n - L - 1) % HW];
      sda = hist_da[(edge_n - 1) % HW];
      sdb = hist_db[(edge_n - 1) % HW];
      m_we_a = '0; m_we_b = '0; m_addr_a = '0; m_addr_b = '0; m_din_a = '0; m_din_b = '0;
      for (int b = 0; b < 8; b++) begin
        cnt_a[b] = 0;
        cnt_b[b] = 0;
      end
      // Highest lane first so the lowest lane's write is the one left standing.
      for (int k = 7; k >= 0; k--) begin
        if (src.valid) begin
          a8 = src.core[8*k +: 8];
          b8 = a8 + src.olen;
          ba = int'(a8) / 32;
          bb = int'(b8) / 32;
          m_we_a[ba] = 1'b1;
          m_addr_a[ba*ADW +: ADW] = ADW'(int'(a8) % 32);
          m_din_a[ba*DW +: DW] = sda[k*DW +: DW];
          cnt_a[ba]++;
          m_we_b[bb] = 1'b1;
          m_addr_b[bb*ADW +: ADW] = ADW'(int'(b8) % 32);
          m_din_b[bb*DW +: DW] = sdb[k*DW +: DW];
          cnt_b[bb]++;
        end
      end
      conf_now = 1'b0;
      for (int b = 0; b < 8; b++) begin
        if (cnt_a[b] > 1 || cnt_b[b] > 1) conf_now = 1'b1;
      end
      nbusy  = (start || bus.valid_i) ? 1'b1 : (m_done ? 1'b0 : m_busy);
      m_done = src.valid && src.last;
      m_conf = (m_conf && !start) || conf_now;
      m_busy = nbusy;
    end
    #1;
  endtask

  // Issue one last-tagged beat and run until its writes are on the outputs.
  task automatic run_beat(input logic [63:0] core, input logic [7:0] olen,
                          input logic st, input logic st_end,
                          input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                          output logic [8*DW-1:0] da, output logic [8*DW-1:0] db);
    bus.valid_i     = 1'b1;
    bus.last_i      = 1'b1;
    bus.addr_core_i = core;
    bus.olen_i      = olen;
    start           = st;
    rand_data();
    tick();
    start = 1'b0;
    set_idle();
    da = '0;
    db = '0;
    for (int i = 1; i <= L + 1; i++) begin
      rand_data();
      if (i == L) begin
        bus.data_a_i[DW-1:0] = a0;
        bus.data_b_i[DW-1:0] = b0;
        da = bus.data_a_i;
        db = bus.data_b_i;
      end
      if (i == L + 1) start = st_end;
      tick();
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    set_idle();
    rand_data();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_outputs got=%h required=0", obs);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_beat();
    logic [63:0]     core;
    logic [8*DW-1:0] da, db;
    for (int k = 0; k < 8; k++) core[8*k +: 8] = 8'(32 * k);
    run_beat(core, 8'h80, 1'b1, 1'b0, 12'h123, 12'h456, da, db);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL single_model got=%h required=%h", obs, exp_v);
    end
    checks++;
    if (bus.we_a_o[0] !== 1'b1 || bus.addr_a_o[4:0] !== 5'd0 || bus.din_a_o[11:0] !== 12'h123) begin
      errors++;
      $display("FAIL single_portA we=%b addr=%0d din=%h required 1/0/123",
               bus.we_a_o[0], bus.addr_a_o[4:0], bus.din_a_o[11:0]);
    end
    checks++;
    if (bus.we_b_o[4] !== 1'b1 || bus.addr_b_o[24:20] !== 5'd0 || bus.din_b_o[59:48] !== 12'h456) begin
      errors++;
      $display("FAIL single_portB we=%b addr=%0d din=%h required 1/0/456",
               bus.we_b_o[4], bus.addr_b_o[24:20], bus.din_b_o[59:48]);
    end
  endtask

  task automatic test_all_lanes();
    logic [63:0]     core;
    logic [8*DW-1:0] da, db;
    int              bad;
    for (int k = 0; k < 8; k++) core[8*k +: 8] = 8'(32 * k + 3);
    run_beat(core, 8'd16, 1'b1, 1'b0, 12'($urandom()), 12'($urandom()), da, db);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL all_lanes_model got=%h required=%h", obs, exp_v);
    end
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.addr_a_o[k*ADW +: ADW] !== 5'd3 || bus.addr_b_o[k*ADW +: ADW] !== 5'd19 ||
          bus.din_a_o[k*DW +: DW] !== da[k*DW +: DW] || bus.din_b_o[k*DW +: DW] !== db[k*DW +: DW])
        bad++;
    end
    checks++;
    if (bus.we_a_o !== 8'hFF || bus.we_b_o !== 8'hFF || bad != 0 || conflict !== 1'b0) begin
      errors++;
      $display("FAIL all_lanes we_a=%h we_b=%h bad_banks=%0d conflict=%b required ff/ff/0/0",
               bus.we_a_o, bus.we_b_o, bad, conflict);
    end
  endtask

  task automatic test_wrap();
    logic [63:0]     core;
    logic [8*DW-1:0] da, db;
    logic [DW-1:0]   b0;
    b0 = 12'($urandom());
    core[7:0] = 8'hF0;
    for (int k = 1; k < 8; k++) core[8*k +: 8] = 8'(32 * (k - 1) + 1);
    run_beat(core, 8'h20, 1'b1, 1'b0, 12'($urandom()), b0, da, db);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL wrap_model got=%h required=%h", obs, exp_v);
    end
    checks++;
    if (bus.we_b_o[0] !== 1'b1 || bus.addr_b_o[4:0] !== 5'd16 || bus.din_b_o[11:0] !== b0) begin
      errors++;
      $display("FAIL wrap_bank0B we=%b addr=%0d din=%h required 1/16/%h",
               bus.we_b_o[0], bus.addr_b_o[4:0], bus.din_b_o[11:0], b0);
    end
  endtask

  task automatic test_conflict();
    logic [63:0]     core;
    logic [8*DW-1:0] da, db;
    logic [DW-1:0]   a0;
    a0 = 12'($urandom());
    core[7:0]  = 8'h05;
    core[15:8] = 8'h05;
    for (int k = 2; k < 8; k++) core[8*k +: 8] = 8'(32 * k);
    run_beat(core, 8'h00, 1'b1, 1'b0, a0, 12'($urandom()), da, db);
    checks++;
    if (bus.we_a_o[0] !== 1'b1 || bus.addr_a_o[4:0] !== 5'd5 || bus.din_a_o[11:0] !== a0 ||
        conflict !== 1'b1) begin
      errors++;
      $display("FAIL conflict_winner we=%b addr=%0d din=%h conflict=%b required 1/5/%h/1",
               bus.we_a_o[0], bus.addr_a_o[4:0], bus.din_a_o[11:0], conflict, a0);
    end
    for (int i = 0; i < 3; i++) begin
      rand_data();
      tick();
      checks++;
      if (conflict !== 1'b1 || obs !== exp_v) begin
        errors++;
        $display("FAIL conflict_sticky conflict=%b got=%h required=%h", conflict, obs, exp_v);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (conflict !== 1'b0) begin
      errors++;
      $display("FAIL conflict_clear conflict=%b required 0", conflict);
    end
    run_beat(core, 8'h00, 1'b0, 1'b1, 12'($urandom()), 12'($urandom()), da, db);
    checks++;
    if (conflict !== 1'b1 || obs !== exp_v) begin
      errors++;
      $display("FAIL conflict_set_wins conflict=%b got=%h required=%h", conflict, obs, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    int   t31 = 0;
    int   done_n = 0;
    int   done_e = -100;
    int   wr_n = 0;
    logic busy_after = 1'b1;
    set_idle();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 32; j++) begin
      bus.valid_i     = 1'b1;
      bus.last_i      = (j == 31);
      bus.addr_core_i = {$urandom(), $urandom()};
      bus.olen_i      = 8'($urandom());
      rand_data();
      tick();
      if (j == 31) t31 = edge_n;
      if (|bus.we_a_o) wr_n++;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL stream_model e=%0d got=%h required=%h", edge_n, obs, exp_v);
      end
    end
    set_idle();
    for (int i = 0; i < L + 4; i++) begin
      rand_data();
      tick();
      if (|bus.we_a_o) wr_n++;
      if (done === 1'b1) begin
        done_n++;
        done_e = edge_n;
      end
      if (edge_n == done_e + 1) busy_after = busy;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL stream_drain e=%0d got=%h required=%h", edge_n, obs, exp_v);
      end
    end
    checks++;
    if (done_n != 1 || done_e != t31 + L + 1 || busy_after !== 1'b0 || wr_n != 32) begin
      errors++;
      $display("FAIL stream_done pulses=%0d at=%0d busy_after=%b writes=%0d required 1/%0d/0/32",
               done_n, done_e, busy_after, wr_n, t31 + L + 1);
    end
  endtask

  task automatic test_reset_midflight();
    int any_we = 0;
    int any_done = 0;
    bus.valid_i     = 1'b1;
    bus.last_i      = 1'b1;
    bus.addr_core_i = {$urandom(), $urandom()};
    bus.olen_i      = 8'($urandom());
    rand_data();
    tick();
    set_idle();
    for (int i = 1; i <= L + 3; i++) begin
      rst_n = (i != 2);
      rand_data();
      tick();
      if (|bus.we_a_o || |bus.we_b_o) any_we++;
      if (done === 1'b1) any_done++;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL midflight_model e=%0d got=%h required=%h", edge_n, obs, exp_v);
      end
    end
    rst_n = 1'b1;
    checks++;
    if (any_we != 0 || any_done != 0 || obs !== '0) begin
      errors++;
      $display("FAIL midflight_discard we_cycles=%0d done_cycles=%0d out=%h required 0/0/0",
               any_we, any_done, obs);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n           = ($urandom_range(63) != 0);
      start           = ($urandom_range(15) == 0);
      bus.valid_i     = ($urandom_range(3) != 0);
      bus.last_i      = ($urandom_range(7) == 0);
      bus.addr_core_i = {$urandom(), $urandom()};
      bus.olen_i      = 8'($urandom());
      rand_data();
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random_model e=%0d got=%h required=%h", edge_n, obs, exp_v);
      end
    end
    rst_n = 1'b1;
    start = 1'b0;
    set_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout e=%0d required completion", edge_n);
    $fatal(1, "bench timeout");
  end

  initial begin
    set_idle();
    rand_data();
    test_reset();
    test_single_beat();
    test_all_lanes();
    test_wrap();
    test_conflict();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
